hex_display_ctrl: RTL and testbench

- Parametrised seven-segment display controller for the soft-processor system, driving the board hex digits through a memory-mapped slave.
- Generalises fixed 7-bit per-digit PIO outputs: digit count is a parameter, and the block adds a hex/decimal display mode, an iterative binary-to-BCD converter, leading-zero blanking and per-digit blinking.
- Sits between the system interconnect and the HEX pins.

---
 rtl/hex_display_pkg.sv | 29 ++
 rtl/bin2bcd_iter.sv | 94 +++++++++
 rtl/hex_display_ctrl.sv | 131 +++++++++++++
 tb/tb_hex_display_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants, segment table and converter states for hex_display_ctrl
package hex_display_pkg;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_LZB    = 1;
  localparam int CTRL_DEC    = 2;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_OVF  = 1;

  // Active-high patterns, bit 0 = segment a; entry 0 sits in the low bits.
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_e;

  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    return SEG_TABLE[7*int'(nib) +: 7];
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// rtl/bin2bcd_iter.sv - iterative double-dabble binary-to-BCD converter with restartable start and overflow flag
module bin2bcd_iter
  import hex_display_pkg::*;
#(
  parameter int W  = 24,
  parameter int ND = 6
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [W-1:0]    bin_in,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd_out,
  output logic            ovf
);

  localparam int CW = $clog2(W + 1);

  conv_state_e    state_q, state_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [4*ND-1:0] bcd_q, bcd_d, bcd_adj;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           load, shift;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        LOAD:  state_d = SHIFT;
        SHIFT: if (cnt_q == CW'(W - 1)) state_d = DONE;
        DONE:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load  = (state_q == LOAD);
    shift = (state_q == SHIFT);
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
  end

  // A 1 shifted out of the top digit means the running value reached 10^ND; keep it sticky.
  always_comb begin
    for (int i = 0; i < ND; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bin_d = bin_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (load) begin
      bin_d = bin_in;
      bcd_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (shift) begin
      {bcd_d, bin_d} = {bcd_adj[4*ND-2:0], bin_q, 1'b0};
      ovf_d = ovf_q | bcd_adj[4*ND-1];
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - memory-mapped seven-segment controller: registers, blink divider, digit mux, output register
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 50000000,
  parameter int BLINK_HZ   = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [1:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] hex_export
);

  localparam int W    = 4 * NUM_DIGITS;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [7*NUM_DIGITS-1:0] HEX_OFF = {(7*NUM_DIGITS){ACTIVE_LOW}};

  logic [W-1:0]            value_q, value_d, latched_q, latched_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic                    ovf_q, ovf_d, phase_q, phase_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [31:0]             rdata_q, rdata_d;

  logic         wr_value, wr_ctrl, wr_blink, conv_start;
  logic         conv_busy, conv_done, conv_ovf, show_dash, lead;
  logic [W-1:0] conv_bcd, digits;
  logic [3:0]   nib;
  logic [6:0]   seg;
  logic         unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign wr_value   = avs_write && (avs_address == ADDR_VALUE);
  assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
  assign wr_blink   = avs_write && (avs_address == ADDR_BLINK);
  assign conv_start = (wr_value && ctrl_q[CTRL_DEC]) || (wr_ctrl && avs_writedata[CTRL_DEC]);

  bin2bcd_iter #(.W(W), .ND(NUM_DIGITS)) u_conv (
    .clk     (clk_clk),
    .resetn  (reset_reset_n),
    .start   (conv_start),
    .bin_in  (value_q),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd),
    .ovf     (conv_ovf)
  );

  always_comb begin
    value_d   = wr_value ? avs_writedata[W-1:0] : value_q;
    ctrl_d    = wr_ctrl ? avs_writedata[2:0] : ctrl_q;
    blink_d   = wr_blink ? avs_writedata[NUM_DIGITS-1:0] : blink_q;
    latched_d = conv_done ? conv_bcd : latched_q;
    if (!ctrl_d[CTRL_DEC]) ovf_d = 1'b0;
    else if (conv_done)    ovf_d = conv_ovf;
    else                   ovf_d = ovf_q;
    bcnt_d  = (bcnt_q == BW'(HALF - 1)) ? '0 : bcnt_q + BW'(1);
    phase_d = (bcnt_q == BW'(HALF - 1)) ? ~phase_q : phase_q;
  end

  always_comb begin
    rdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        ADDR_VALUE: rdata_d[W-1:0]          = value_q;
        ADDR_CTRL:  rdata_d[2:0]            = ctrl_q;
        ADDR_BLINK: rdata_d[NUM_DIGITS-1:0] = blink_q;
        default: begin
          rdata_d[STATUS_BUSY] = conv_busy;
          rdata_d[STATUS_OVF]  = ovf_q;
        end
      endcase
    end
  end

  // The DONE cycle bypasses the latch so a fresh result reaches the pins in the same edge it is latched.
  always_comb begin
    digits    = ctrl_q[CTRL_DEC] ? (conv_done ? conv_bcd : latched_q) : value_q;
    show_dash = ctrl_q[CTRL_DEC] && (conv_done ? conv_ovf : ovf_q);
    lead      = 1'b1;
    nib       = '0;
    seg       = SEG_BLANK;
    hex_d     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib  = digits[4*k +: 4];
      lead = lead && (nib == 4'd0);
      seg  = seg_lookup(nib);
      if (show_dash) seg = SEG_DASH;
      else if (ctrl_q[CTRL_LZB] && lead && (k != 0)) seg = SEG_BLANK;
      if (!ctrl_q[CTRL_EN] || (blink_q[k] && !phase_q)) seg = SEG_BLANK;
      hex_d[7*k +: 7] = ACTIVE_LOW ? ~seg : seg;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      value_q   <= '0;
      ctrl_q    <= 3'b001;
      blink_q   <= '0;
      latched_q <= '0;
      ovf_q     <= 1'b0;
      bcnt_q    <= '0;
      phase_q   <= 1'b1;
      hex_q     <= HEX_OFF;
      rdata_q   <= '0;
    end else begin
      value_q   <= value_d;
      ctrl_q    <= ctrl_d;
      blink_q   <= blink_d;
      latched_q <= latched_d;
      ovf_q     <= ovf_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      hex_q     <= hex_d;
      rdata_q   <= rdata_d;
    end
  end

  assign hex_export   = hex_q;
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - directed self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic        wr, rd;
  logic [31:0] wdata, rdata, d;
  logic [41:0] hex;
  logic        seen, found;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S9 = 7'h10, SA = 7'h08;
  localparam logic [6:0] SB = 7'h03, SD = 7'h3F, SX = 7'h7F;
  localparam logic [41:0] OLD_DEC = {S0, S4, S1, S3, S9, S4};
  localparam logic [41:0] SEVEN   = {SX, SX, SX, SX, SX, S7};

  hex_display_ctrl #(.NUM_DIGITS(6), .CLK_HZ(16), .BLINK_HZ(2), .ACTIVE_LOW(1'b1)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs_address   (addr),
    .avs_write     (wr),
    .avs_writedata (wdata),
    .avs_read      (rd),
    .avs_readdata  (rdata),
    .hex_export    (hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
    addr = a; wdata = v; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] q);
    addr = a; rd = 1'b1;
    @(negedge clk);
    q = rdata; rd = 1'b0;
  endtask

  task automatic bus_rw(input logic [1:0] a, input logic [31:0] v, output logic [31:0] q);
    addr = a; wdata = v; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    q = rdata; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      @(negedge clk);
      if (hex === {6{S1}}) seen = 1'b1;
    end
  endtask

  task automatic wait_d0(input logic want_blank, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if ((hex[6:0] == SX) == want_blank) ok = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; seen = 1'b0;
    idle(4);
    check("reset_hex", hex, {6{SX}});
    check("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_hex", hex, {6{S0}});
    bus_rd(2'd3, d); check("reset_status", d, 32'h0);
    bus_rd(2'd1, d); check("reset_ctrl", d, 32'h1);
    bus_rd(2'd2, d); check("reset_blink", d, 32'h0);
    bus_wr(2'd3, 32'h3);
    bus_rd(2'd3, d); check("status_wr_ignored", d, 32'h0);
    bus_rw(2'd0, 32'hFF123456, d); check("rw_same_cycle_old", d, 32'h0);
    bus_rd(2'd0, d); check("value_truncated", d, 32'h00123456);

    bus_wr(2'd0, 32'h0000A1B2);
    check("hex_t1_old", hex, {S1, S2, S3, S4, S5, S6});
    @(negedge clk);
    check("hex_t2", hex, {S0, S0, SA, S1, SB, S2});
    bus_wr(2'd1, 32'h3);
    idle(1);
    check("hex_lzb", hex, {SX, SX, SA, S1, SB, S2});

    bus_wr(2'd1, 32'h5);
    idle(30);
    check("dec_first_conv", hex, OLD_DEC);
    bus_wr(2'd0, 32'd123456);
    bus_rd(2'd3, d); check("dec_busy_t1", d, 32'h1);
    check("dec_hold_t2", hex, OLD_DEC);
    idle(24);
    check("dec_hold_t26", hex, OLD_DEC);
    bus_rd(2'd3, d); check("dec_busy_t26", d, 32'h1);
    check("dec_digits_t27", hex, {S1, S2, S3, S4, S5, S6});
    bus_rd(2'd3, d); check("dec_idle_t27", d, 32'h0);

    bus_wr(2'd0, 32'd1000000);
    idle(30);
    check("ovf_dashes", hex, {6{SD}});
    bus_rd(2'd3, d); check("ovf_status", d, 32'h2);
    bus_wr(2'd1, 32'h7);
    bus_wr(2'd0, 32'd7);
    idle(30);
    check("ovf_clear_hex", hex, SEVEN);
    bus_rd(2'd3, d); check("ovf_clear_status", d, 32'h0);

    bus_wr(2'd0, 32'd111111);
    watch(9);
    bus_wr(2'd0, 32'd222222);
    watch(25);
    check("restart_hold", hex, SEVEN);
    watch(1);
    check("restart_new", hex, {6{S2}});
    check("restart_never_111111", seen, 1'b0);

    bus_wr(2'd1, 32'h1);
    bus_wr(2'd0, 32'h12);
    bus_wr(2'd2, 32'h1);
    idle(2);
    wait_d0(1'b0, found); check("blink_sync_on", found, 1'b1);
    wait_d0(1'b1, found); check("blink_sync_off", found, 1'b1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("blink_d0_%0d", i), hex[6:0], ((i % 8) < 4) ? SX : S2);
      check($sformatf("blink_rest_%0d", i), hex[41:7], {S0, S0, S0, S0, S1});
      @(negedge clk);
    end

    bus_wr(2'd1, 32'h0);
    idle(1);
    check("en_off_blank", hex, {6{SX}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
